// File: rtl/generic_rotate_pkg.sv
// Shared types and width helpers for the rotate packer.
`ifndef GENERIC_ROTATE_LANE_T
`define GENERIC_ROTATE_LANE_T(W) logic [(W)-1:0]
`endif

package generic_rotate_pkg;

    // Flush state: IDLE accepts input, DRAIN empties storage with partial words allowed.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Bits needed to hold a count in the range 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index max_val entries.
    function automatic int ptr_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/generic_rotate_packer_if.sv
// Bus bundle for the rotate packer: input beat stream, output word stream, flush control.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge where
// valid and ready are both high. The source holds valid/payload steady until that edge;
// ready never depends combinationally on valid in this block.
interface generic_rotate_packer_if
    import generic_rotate_pkg::*;
#(
    parameter int NUM_IN    = 6,
    parameter int NUM_OUT   = 8,
    parameter int DATA_SIZE = 10
);
    localparam int IN_CNT_W  = cnt_width(NUM_IN);
    localparam int OUT_CNT_W = cnt_width(NUM_OUT);

    logic                          in_valid;
    logic [IN_CNT_W-1:0]           in_cnt;
    logic [NUM_IN*DATA_SIZE-1:0]   in_data;
    logic                          in_ready;

    logic                          out_valid;
    logic [OUT_CNT_W-1:0]          out_cnt;
    logic [NUM_OUT*DATA_SIZE-1:0]  out_data;
    logic                          out_ready;

    logic                          flush_req;
    logic                          flush_done;
    logic                          err;

    // Producer/consumer side (the environment around the packer).
    modport master (
        output in_valid, in_cnt, in_data, out_ready, flush_req,
        input  in_ready, out_valid, out_cnt, out_data, flush_done, err
    );

    // The packer itself.
    modport slave (
        input  in_valid, in_cnt, in_data, out_ready, flush_req,
        output in_ready, out_valid, out_cnt, out_data, flush_done, err
    );

endinterface

// File: rtl/generic_rotate_append.sv
// Combinational lane placer: rotates the input beat left by the write offset into
// CAP storage lanes and flags which lanes receive new entries.
module generic_rotate_append
    import generic_rotate_pkg::*;
#(
    parameter int NUM_IN    = 6,
    parameter int DATA_SIZE = 10,
    parameter int CAP       = 16,
    localparam int IN_CNT_W = cnt_width(NUM_IN),
    localparam int OFF_W    = cnt_width(CAP)
) (
    input  logic [NUM_IN*DATA_SIZE-1:0] i_data,
    input  logic [IN_CNT_W-1:0]         i_cnt,
    input  logic [OFF_W-1:0]            i_offset,
    output logic [CAP*DATA_SIZE-1:0]    o_lanes,
    output logic [CAP-1:0]              o_we
);

    logic [CAP*DATA_SIZE-1:0] w_ext;

    // Zero-extend the beat to CAP lanes so the rotation never pulls in stale data.
    always_comb begin
        w_ext = '0;
        w_ext[NUM_IN*DATA_SIZE-1:0] = i_data;
    end

    // Rotate left by the offset; only lanes offset..offset+cnt-1 are write-enabled.
    // The caller guarantees offset+cnt <= CAP, so the mask never wraps.
    always_comb begin
        o_lanes = '0;
        o_we    = '0;
        for (int j = 0; j < CAP; j++) begin
            int src;
            src = j - int'(i_offset);
            if (src < 0) begin
                src = src + CAP;
            end
            o_lanes[j*DATA_SIZE +: DATA_SIZE] = w_ext[src*DATA_SIZE +: DATA_SIZE];
            o_we[j] = (j >= int'(i_offset)) && (j < int'(i_offset) + int'(i_cnt));
        end
    end

endmodule

// File: rtl/generic_rotate_packer.sv
// Lane packer: appends 0..NUM_IN entries per beat behind stored entries and emits
// dense NUM_OUT-wide words; flush drains a zero-padded partial word.
module generic_rotate_packer
    import generic_rotate_pkg::*;
#(
    parameter int NUM_IN    = 6,
    parameter int NUM_OUT   = 8,
    parameter int DATA_SIZE = 10,
    parameter int CAP       = 2 * NUM_OUT,
    localparam int CNT_W    = cnt_width(CAP)
) (
    input  logic                       clk,
    input  logic                       reset,
    generic_rotate_packer_if.slave     bus,
    output state_e                     o_dbg_state,
    output logic [CNT_W-1:0]           o_dbg_cnt
);

    localparam int IN_CNT_W  = cnt_width(NUM_IN);
    localparam int OUT_CNT_W = cnt_width(NUM_OUT);

    typedef `GENERIC_ROTATE_LANE_T(DATA_SIZE) lane_t;

    // Registered state
    lane_t                   r_buf [CAP];
    logic [CNT_W-1:0]        r_cnt;
    state_e                  r_state;
    logic                    r_flush_done;
    logic                    r_err;

    // Combinational signals
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_pop;
    logic                    w_push;
    logic [CNT_W-1:0]        w_out_cnt;
    logic [CNT_W-1:0]        w_pop_cnt;
    logic [IN_CNT_W-1:0]     w_in_cnt_eff;
    logic [IN_CNT_W-1:0]     w_push_cnt;
    logic [CNT_W-1:0]        w_wr_off;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_in_cnt_bad;
    lane_t                   w_shift [CAP];
    logic [CAP*DATA_SIZE-1:0] w_app_flat;
    logic [CAP-1:0]          w_we;
    logic [NUM_OUT*DATA_SIZE-1:0] w_out_data;
    state_e                  w_state_nxt;
    logic                    w_flush_done_nxt;

    // Handshake and count decode; ready and valid come from registered state only.
    always_comb begin
        w_in_ready   = !reset && (r_state == ST_IDLE) && (int'(r_cnt) + NUM_IN <= CAP);
        w_out_valid  = !reset && ((int'(r_cnt) >= NUM_OUT) ||
                                  ((r_state == ST_DRAIN) && (r_cnt != '0)));
        w_out_cnt    = (int'(r_cnt) >= NUM_OUT) ? CNT_W'(NUM_OUT) : r_cnt;
        w_pop        = w_out_valid && bus.out_ready;
        w_push       = bus.in_valid && w_in_ready;
        w_pop_cnt    = w_pop ? w_out_cnt : '0;
        w_in_cnt_bad = int'(bus.in_cnt) > NUM_IN;
        w_in_cnt_eff = w_in_cnt_bad ? IN_CNT_W'(NUM_IN) : bus.in_cnt;
        w_push_cnt   = w_push ? w_in_cnt_eff : '0;
        w_wr_off     = r_cnt - w_pop_cnt;
        w_cnt_nxt    = r_cnt - w_pop_cnt + CNT_W'(w_push_cnt);
    end

    // Output word: head lanes below out_cnt, everything above forced to zero.
    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (i < int'(w_out_cnt)) begin
                w_out_data[i*DATA_SIZE +: DATA_SIZE] = r_buf[i];
            end
        end
    end

    // Pop shifter: move storage down by the popped lane count, zero-filling the top.
    always_comb begin
        for (int i = 0; i < CAP; i++) begin
            w_shift[i] = '0;
            for (int k = 0; k <= NUM_OUT; k++) begin
                if ((int'(w_pop_cnt) == k) && (i + k < CAP)) begin
                    w_shift[i] = r_buf[(i + k) % CAP];
                end
            end
        end
    end

    generic_rotate_append #(
        .NUM_IN    (NUM_IN),
        .DATA_SIZE (DATA_SIZE),
        .CAP       (CAP)
    ) u_append (
        .i_data   (bus.in_data),
        .i_cnt    (w_push_cnt),
        .i_offset (w_wr_off),
        .o_lanes  (w_app_flat),
        .o_we     (w_we)
    );

    // Flush FSM: completion is judged on the post-update count, so the done pulse lands
    // the cycle after storage empties (or right after the request if already empty).
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    if (w_cnt_nxt == '0) begin
                        w_flush_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_cnt_nxt == '0) begin
                    w_state_nxt      = ST_IDLE;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Storage update: newly placed lanes win over the shifted contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < CAP; j++) begin
                r_buf[j] <= '0;
            end
        end else begin
            for (int j = 0; j < CAP; j++) begin
                r_buf[j] <= w_we[j] ? w_app_flat[j*DATA_SIZE +: DATA_SIZE] : w_shift[j];
            end
        end
    end

    // Control registers: occupancy, flush state, done pulse and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_state      <= ST_IDLE;
            r_flush_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
            if (w_push && w_in_cnt_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_cnt    = OUT_CNT_W'(w_out_cnt);
    assign bus.out_data   = w_out_data;
    assign bus.flush_done = r_flush_done;
    assign bus.err        = r_err;
    assign o_dbg_state    = r_state;
    assign o_dbg_cnt      = r_cnt;

endmodule

// File: tb/tb_generic_rotate_packer.sv
// Self-checking bench for generic_rotate_packer: directed vector table, hand-written
// reset/flush sequences and randomized traffic against a queue-based reference model.
module tb_generic_rotate_packer;
  import generic_rotate_pkg::*;

  localparam int NI  = 6;
  localparam int NO  = 8;
  localparam int DS  = 10;
  localparam int CAP = 16;

  typedef struct {
    bit          iv;
    logic [2:0]  ic;
    bit          ordy;
    bit          fr;
    bit          e_ir;
    bit          e_ov;
    logic [3:0]  e_oc;
    logic [4:0]  e_cnt;
    bit          e_fd;
    bit          e_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  state_e     dbg_state;
  logic [4:0] dbg_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generic_rotate_packer_if #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_SIZE(DS)) bus ();

  generic_rotate_packer #(
    .NUM_IN(NI), .NUM_OUT(NO), .DATA_SIZE(DS), .CAP(CAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state),
    .o_dbg_cnt  (dbg_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  logic [DS-1:0] exp_q[$];
  bit            m_pend;
  bit            m_done;
  bit            m_err;
  int            checks;
  int            errors;
  int            seq;
  vec_t          vt[22];
  vec_t          none;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit iv, int ic, bit ordy, bit fr, bit e_ir, bit e_ov,
                              int e_oc, int e_cnt, bit e_fd, bit e_err);
    vec_t v;
    v.iv = iv; v.ic = 3'(ic); v.ordy = ordy; v.fr = fr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = 4'(e_oc); v.e_cnt = 5'(e_cnt);
    v.e_fd = e_fd; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- driver: one clock cycle, checked against the model ----------------
  task automatic step(input bit rst, input bit iv, input logic [2:0] ic,
                      input logic [NI*DS-1:0] idata, input bit ordy, input bit fr,
                      input bit use_v, input vec_t v);
    int          sz;
    bit          e_ir;
    bit          e_ov;
    int          e_oc;
    int          n;
    logic [79:0] e_od;
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_cnt    = ic;
    bus.in_data   = idata;
    bus.out_ready = ordy;
    bus.flush_req = fr;
    #1;
    sz   = exp_q.size();
    e_ir = !rst && !m_pend && (sz + NI <= CAP);
    e_ov = !rst && ((sz >= NO) || (m_pend && sz != 0));
    e_oc = (sz < NO) ? sz : NO;
    e_od = '0;
    for (int i = 0; i < e_oc; i++) e_od[i*DS +: DS] = exp_q[i];
    chk("in_ready",   80'(bus.in_ready),   80'(e_ir));
    chk("out_valid",  80'(bus.out_valid),  80'(e_ov));
    chk("out_cnt",    80'(bus.out_cnt),    80'(e_oc));
    chk("out_data",   80'(bus.out_data),   e_od);
    chk("occupancy",  80'(dbg_cnt),        80'(sz));
    chk("flush_done", 80'(bus.flush_done), 80'(m_done));
    chk("err",        80'(bus.err),        80'(m_err));
    chk("drain_state", 80'(dbg_state == ST_DRAIN), 80'(m_pend));
    if (use_v) begin
      chk("vec_in_ready",   80'(bus.in_ready),   80'(v.e_ir));
      chk("vec_out_valid",  80'(bus.out_valid),  80'(v.e_ov));
      chk("vec_out_cnt",    80'(bus.out_cnt),    80'(v.e_oc));
      chk("vec_cnt",        80'(dbg_cnt),        80'(v.e_cnt));
      chk("vec_flush_done", 80'(bus.flush_done), 80'(v.e_fd));
      chk("vec_err",        80'(bus.err),        80'(v.e_err));
    end
    @(posedge clk);
    // Model update: pop the head word, append the accepted lanes, then resolve flush.
    if (rst) begin
      exp_q.delete();
      m_pend = 0;
      m_done = 0;
      m_err  = 0;
    end else begin
      if (e_ov && ordy) repeat (e_oc) void'(exp_q.pop_front());
      if (iv && e_ir) begin
        n = (int'(ic) > NI) ? NI : int'(ic);
        if (int'(ic) > NI) m_err = 1;
        for (int i = 0; i < n; i++) exp_q.push_back(idata[i*DS +: DS]);
      end
      m_done = 0;
      if (m_pend || fr) begin
        if (exp_q.size() == 0) begin
          m_pend = 0;
          m_done = 1;
        end else begin
          m_pend = 1;
        end
      end
    end
  endtask

  function automatic logic [NI*DS-1:0] seq_data(int base);
    logic [NI*DS-1:0] d;
    for (int i = 0; i < NI; i++) d[i*DS +: DS] = DS'(base + i + 1);
    return d;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0]      r64;
    logic [NI*DS-1:0] rd;
    bit               rrst, riv, rordy, rfr;
    logic [2:0]       ric;
    int               ordy_pct;

    checks = 0; errors = 0; seq = 0;
    m_pend = 0; m_done = 0; m_err = 0;
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed table: inputs for the cycle, and outputs expected before its edge.
    //           iv ic or fr | ir ov oc cnt fd err
    vt[0]  = mk(1, 6, 0, 0,   1, 0, 0, 0,  0, 0);  // push A0..A5
    vt[1]  = mk(1, 6, 0, 0,   1, 0, 6, 6,  0, 0);  // push B0..B5
    vt[2]  = mk(1, 4, 0, 0,   0, 1, 8, 12, 0, 0);  // full: 12+6>16
    vt[3]  = mk(1, 4, 1, 0,   0, 1, 8, 12, 0, 0);  // pop A0..A5,B0,B1
    vt[4]  = mk(1, 4, 0, 0,   1, 0, 4, 4,  0, 0);  // push 4 after pop
    vt[5]  = mk(0, 0, 1, 0,   1, 1, 8, 8,  0, 0);  // pop full word
    vt[6]  = mk(1, 4, 0, 0,   1, 0, 0, 0,  0, 0);  // refill to 4
    vt[7]  = mk(0, 0, 0, 1,   1, 0, 4, 4,  0, 0);  // flush at cnt 4
    vt[8]  = mk(1, 2, 0, 0,   0, 1, 4, 4,  0, 0);  // draining, partial word
    vt[9]  = mk(0, 0, 1, 0,   0, 1, 4, 4,  0, 0);  // pop partial
    vt[10] = mk(0, 0, 0, 0,   1, 0, 0, 0,  1, 0);  // flush_done pulse
    vt[11] = mk(1, 6, 0, 0,   1, 0, 0, 0,  0, 0);
    vt[12] = mk(1, 2, 0, 0,   1, 0, 6, 6,  0, 0);
    vt[13] = mk(1, 6, 1, 0,   1, 1, 8, 8,  0, 0);  // pop 8 + push 6
    vt[14] = mk(0, 0, 0, 1,   1, 0, 6, 6,  0, 0);  // flush at cnt 6
    vt[15] = mk(0, 0, 1, 0,   0, 1, 6, 6,  0, 0);
    vt[16] = mk(0, 0, 0, 0,   1, 0, 0, 0,  1, 0);
    vt[17] = mk(0, 0, 0, 1,   1, 0, 0, 0,  0, 0);  // flush when empty
    vt[18] = mk(0, 0, 0, 0,   1, 0, 0, 0,  1, 0);
    vt[19] = mk(1, 7, 0, 0,   1, 0, 0, 0,  0, 0);  // in_cnt 7 -> err
    vt[20] = mk(0, 0, 0, 1,   1, 0, 6, 6,  0, 1);  // flush, then reset mid-drain
    vt[21] = mk(1, 3, 0, 1,   0, 1, 6, 6,  0, 1);  // repeat flush_req ignored

    bus.in_valid = 0; bus.in_cnt = '0; bus.in_data = '0;
    bus.out_ready = 0; bus.flush_req = 0;
    reset = 1;
    repeat (2) @(posedge clk);

    // Reset held: no handshakes offered.
    repeat (3) step(1, 1, 3'd6, seq_data(900), 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Directed vectors.
    for (int r = 0; r < 22; r++) begin
      step(0, vt[r].iv, vt[r].ic, seq_data(seq), vt[r].ordy, vt[r].fr, 1, vt[r]);
      seq += NI;
    end

    // Reset mid-flush: state discarded, err cleared, no flush_done afterwards.
    step(1, 0, 3'd0, '0, 0, 0, 0, none);
    repeat (3) step(0, 0, 3'd0, '0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Randomized traffic with varying backpressure.
    ordy_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) ordy_pct = $urandom_range(10, 100);
      r64   = {$urandom, $urandom};
      rd    = r64[NI*DS-1:0];
      rrst  = ($urandom_range(0, 499) == 0);
      riv   = ($urandom_range(0, 3) != 0);
      ric   = ($urandom_range(0, 40) == 0) ? 3'd7 : 3'($urandom_range(0, NI));
      rordy = ($urandom_range(1, 100) <= ordy_pct);
      rfr   = ($urandom_range(0, 29) == 0);
      step(rrst, riv, ric, rd, rordy, rfr, 0, none);
    end

    // Final drain with flush.
    step(0, 0, 3'd0, '0, 1, 1, 0, none);
    repeat (6) step(0, 0, 3'd0, '0, 1, 0, 0, none);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
